io_cmd_sequencer: RTL
=====================

# io_cmd_sequencer

Host-side command sequencer directly upstream of the asynchronous PRU's IO port (`in`, `io_opcode`, `out`). It accepts whole-word commands (memory write, memory read, config shift, monitor sample) over a valid/ready interface. It serialises each payload into the IO shift register chunk by chunk, issues the matching IO opcode, and captures the PRU's 32-bit `out` into a valid/ready response channel. It turns the pin-level IO protocol into a transaction interface for the test harness / host bridge.

## Interface
- `INPUT_DATA_L`, default `periphery_pkg::INPUT_DATA_L`: width of the `in` chunk bus.
- `INPUT_REG_L`, default `periphery_pkg::INPUT_REG_L`: IO shift-register width. Must be a multiple of `INPUT_DATA_L`. N_BEATS = INPUT_REG_L/INPUT_DATA_L.
- `IO_OPCODE_L`, default `periphery_pkg::IO_OPCODE_L`: opcode width.
- `OUT_L`, default `periphery_pkg::OUTPUT_DATA_L` (32): width of `out` and of the response.
- `RD_LAT`, default 2: cycles from the RD opcode cycle to valid `out` (range ≥1).

Ports:
- `clk`, in, 1: clock; single clock domain.
- `rst`, in, 1: reset, synchronous, active-low.
- `cmd_vld`, in, 1: command valid.
- `cmd_rdy`, out, 1: command ready.
- `cmd_op`, in, 2: command type, `cmd_op_t` (WRITE=0, READ=1, CONFIG=2, MONITOR=3).
- `cmd_payload`, in, INPUT_REG_L: word to shift into the IO register.
- `rsp_vld`, out, 1: response valid.
- `rsp_rdy`, in, 1: response ready.
- `rsp_data`, out, OUT_L: captured `out`.
- `io_in`, out, INPUT_DATA_L: drives PRU `in`.
- `io_opcode`, out, IO_OPCODE_L: drives PRU `io_opcode`.
- `io_out`, in, OUT_L: PRU `out`.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, SHIFT, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_rdy`=1.
  - On `cmd_vld&&cmd_rdy`, latch `cmd_op`/`cmd_payload`, clear the beat counter, and go to SHIFT.
- SHIFT:
  - Drive `io_opcode`=IO_REG_SHIFT and `io_in`=payload chunk, most-significant chunk first (beat k sends bits [INPUT_REG_L-1-k·INPUT_DATA_L -: INPUT_DATA_L]).
  - After beat N_BEATS-1, go to ISSUE.
- ISSUE (exactly 1 cycle), by op:
  - WRITE: `io_opcode`=IO_WR, then IDLE. No response is produced.
  - READ: `io_opcode`=IO_RD, then WAIT.
  - CONFIG: `io_opcode`=IO_CONFIG_SHIFT, `io_in`=0. Capture `io_out` in this cycle (config word shifted out), then RESP.
  - MONITOR: `io_opcode`=IO_MONITOR. Capture `io_out` in this cycle, then RESP.
- WAIT:
  - `io_opcode`=IO_NOP. Count RD_LAT-1 further cycles.
  - Capture `io_out` in the cycle that is RD_LAT cycles after the ISSUE cycle, then RESP.
- RESP:
  - `rsp_vld`=1 with `rsp_data` stable until `rsp_rdy`, then IDLE.
  - `rsp_data` holds its last value afterwards.
- In every state and cycle not listed above: `io_opcode`=IO_NOP and `io_in`=0.
- Beat counter width is `$clog2(N_BEATS)` (minimum 1 bit). It never wraps mid-command; it resets on entry to SHIFT.
- No command is accepted while `busy` (`cmd_rdy`=0 outside IDLE). There is no pipelining and at most one response is outstanding.

## Timing
- Reset (`rst`=0 at a clock edge) values:
  - State: IDLE.
  - `cmd_rdy`=1 after reset, `rsp_vld`=0, `rsp_data`=0, `io_in`=0, `io_opcode`=IO_NOP, `busy`=0.
- Reset mid-command aborts the command immediately. `io_opcode` returns to IO_NOP on the next cycle and no response is produced.
- Command accepted at edge T:
  - Shift beats occupy cycles T+1 … T+N_BEATS.
  - ISSUE is at cycle T+N_BEATS+1.
- `cmd_rdy` returns high:
  - WRITE: at T+N_BEATS+2.
  - CONFIG/MONITOR: `rsp_vld` rises at T+N_BEATS+2.
  - READ: `rsp_vld` rises at T+N_BEATS+1+RD_LAT+1.
- `cmd_rdy` is high in the cycle after the `rsp_rdy` handshake.
- Outputs `io_in`/`io_opcode` are registered, with no combinational path from `cmd_*` to `io_*`. `cmd_rdy`, `rsp_vld` and `busy` are decoded from the state register.
- `rsp_rdy` held low stalls indefinitely in RESP. `io_opcode` stays IO_NOP throughout the stall.

## Structure
- Shared package `periphery_pkg`:
  - Opcode constants IO_NOP, IO_REG_SHIFT, IO_WR, IO_RD, IO_CONFIG_SHIFT, IO_MONITOR (the same encoding `io_decode` consumes).
  - `cmd_op_t` enum.
- Local to the module: the state enum `io_seq_state_t`.
- One sub-module: `io_payload_serializer`. It takes a load strobe and payload, plus a beat strobe, and produces the current chunk and last_beat. The FSM stays in the top.

## Test plan
- INPUT_DATA_L=8, INPUT_REG_L=32, RD_LAT=2.
- WRITE 0xA1B2C3D4 at T -> `io_in`=A1,B2,C3,D4 with IO_REG_SHIFT at T+1..T+4; IO_WR at T+5; `cmd_rdy`=1 at T+6; no `rsp_vld`.
- READ, payload 0x00000040, `io_out` model returns 0x12345678 two cycles after IO_RD (T+5) -> `rsp_vld` at T+8, `rsp_data`=0x12345678.
- CONFIG 0x0000FFFF with `io_out`=0xDEADBEEF during the IO_CONFIG_SHIFT cycle -> `rsp_data`=0xDEADBEEF; `rsp_rdy` low for 5 cycles -> `rsp_vld`/`rsp_data` stable, `io_opcode`=IO_NOP, `cmd_vld` ignored.
- Back-to-back MONITOR commands with `cmd_vld` held high -> second accepted the cycle after the first response handshake; two responses in order.
- `rst`=0 during beat 2 of a WRITE -> next cycle `io_opcode`=IO_NOP, `busy`=0, `cmd_rdy`=1; IO_WR never issued.

Source files
------------

// File: rtl/periphery_pkg.sv
// periphery_pkg: definitions shared by the host-side IO command sequencer
// and the PRU IO decoder.
// Contents:
//   - default widths of the IO port: chunk bus, shift register, opcode, out word
//   - IO opcode encoding, the same one io_decode consumes
//   - cmd_op_t, the transaction-level command type
package periphery_pkg;

    localparam int INPUT_DATA_L  = 8;
    localparam int INPUT_REG_L   = 32;
    localparam int IO_OPCODE_L   = 3;
    localparam int OUTPUT_DATA_L = 32;

    localparam logic [IO_OPCODE_L-1:0] IO_NOP          = 3'd0;
    localparam logic [IO_OPCODE_L-1:0] IO_REG_SHIFT    = 3'd1;
    localparam logic [IO_OPCODE_L-1:0] IO_WR           = 3'd2;
    localparam logic [IO_OPCODE_L-1:0] IO_RD           = 3'd3;
    localparam logic [IO_OPCODE_L-1:0] IO_CONFIG_SHIFT = 3'd4;
    localparam logic [IO_OPCODE_L-1:0] IO_MONITOR      = 3'd5;

    typedef enum logic [1:0] {
        CMD_WRITE   = 2'd0,
        CMD_READ    = 2'd1,
        CMD_CONFIG  = 2'd2,
        CMD_MONITOR = 2'd3
    } cmd_op_t;

endpackage

// File: rtl/io_cmd_sequencer_if.sv
// io_cmd_sequencer_if: command and response channels of the IO command sequencer.
// Signals:
//   cmd_vld/cmd_rdy/cmd_op/cmd_payload : command channel (host -> sequencer)
//   rsp_vld/rsp_rdy/rsp_data           : response channel (sequencer -> host)
// Modports:
//   master : the host side, which drives the commands and accepts the responses
//   slave  : the sequencer side
interface io_cmd_sequencer_if
    import periphery_pkg::*;
#(
    parameter int INPUT_REG_L = periphery_pkg::INPUT_REG_L,
    parameter int OUT_L       = periphery_pkg::OUTPUT_DATA_L
);

    logic                   cmd_vld;
    logic                   cmd_rdy;
    cmd_op_t                cmd_op;
    logic [INPUT_REG_L-1:0] cmd_payload;
    logic                   rsp_vld;
    logic                   rsp_rdy;
    logic [OUT_L-1:0]       rsp_data;

    modport master (
        output cmd_vld, cmd_op, cmd_payload, rsp_rdy,
        input  cmd_rdy, rsp_vld, rsp_data
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_payload, rsp_rdy,
        output cmd_rdy, rsp_vld, rsp_data
    );

endinterface

// File: rtl/io_payload_serializer.sv
// io_payload_serializer: splits a payload word into INPUT_DATA_L chunks,
// most-significant chunk first.
// Ports:
//   clk, rst     : clock and synchronous active-low reset
//   load_i       : captures payload_i and restarts at beat 0
//   payload_i    : word to serialise
//   beat_i       : advances to the next chunk; it is ignored on the last beat
//   chunk_o      : chunk for the beat about to be driven. While load_i is high
//                  this is the first chunk of payload_i. Otherwise it is the
//                  chunk after the one currently being driven.
//   last_beat_o  : the beat currently being driven is beat N_BEATS-1
module io_payload_serializer #(
    parameter int INPUT_DATA_L = periphery_pkg::INPUT_DATA_L,
    parameter int INPUT_REG_L  = periphery_pkg::INPUT_REG_L
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [INPUT_REG_L-1:0]  payload_i,
    input  logic                    beat_i,
    output logic [INPUT_DATA_L-1:0] chunk_o,
    output logic                    last_beat_o
);

    localparam int N_BEATS = INPUT_REG_L / INPUT_DATA_L;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    // The register keeps only the chunks that have not yet been handed out.
    // Its top chunk is therefore always the next one to drive.
    logic [INPUT_REG_L-1:0] sreg_q, sreg_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;

    assign last_beat_o = (beat_q == BEAT_W'(N_BEATS - 1));
    assign chunk_o     = load_i ? payload_i[INPUT_REG_L-1 -: INPUT_DATA_L]
                                : sreg_q[INPUT_REG_L-1 -: INPUT_DATA_L];

    // Next-state logic for the remaining-chunk register and the beat counter.
    always_comb begin
        sreg_d = sreg_q;
        beat_d = beat_q;
        if (load_i) begin
            sreg_d = payload_i << INPUT_DATA_L;
            beat_d = {BEAT_W{1'b0}};
        end else if (beat_i && !last_beat_o) begin
            sreg_d = sreg_q << INPUT_DATA_L;
            beat_d = beat_q + BEAT_W'(1);
        end else begin
            sreg_d = sreg_q;
            beat_d = beat_q;
        end
    end

    // State registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg_q <= {INPUT_REG_L{1'b0}};
            beat_q <= {BEAT_W{1'b0}};
        end else begin
            sreg_q <= sreg_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/io_cmd_sequencer.sv
// io_cmd_sequencer: turns whole-word commands into the pin-level PRU IO
// protocol. Each command proceeds as follows:
//   1. The payload is shifted into the IO register chunk by chunk.
//   2. The IO opcode that matches the command is issued.
//   3. Except for WRITE, the PRU's out word is captured into a response.
// Ports:
//   clk, rst   : clock and synchronous active-low reset
//   cmd_bus    : command/response channels (slave modport)
//   io_in      : registered chunk bus to the PRU `in`
//   io_opcode  : registered opcode to the PRU `io_opcode`
//   io_out     : PRU `out`, captured for READ/CONFIG/MONITOR responses
//   busy       : high in every state except IDLE
module io_cmd_sequencer
    import periphery_pkg::*;
#(
    parameter int INPUT_DATA_L = periphery_pkg::INPUT_DATA_L,
    parameter int INPUT_REG_L  = periphery_pkg::INPUT_REG_L,
    parameter int IO_OPCODE_L  = periphery_pkg::IO_OPCODE_L,
    parameter int OUT_L        = periphery_pkg::OUTPUT_DATA_L,
    parameter int RD_LAT       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    io_cmd_sequencer_if.slave       cmd_bus,
    output logic [INPUT_DATA_L-1:0] io_in,
    output logic [IO_OPCODE_L-1:0]  io_opcode,
    input  logic [OUT_L-1:0]        io_out,
    output logic                    busy
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } io_seq_state_t;

    io_seq_state_t           state_q, state_d;
    cmd_op_t                 op_q, op_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [OUT_L-1:0]        rsp_data_q, rsp_data_d;
    logic [INPUT_DATA_L-1:0] io_in_q, io_in_d;
    logic [IO_OPCODE_L-1:0]  io_opcode_q, io_opcode_d;

    logic                    ser_load_s;
    logic                    ser_beat_s;
    logic [INPUT_DATA_L-1:0] ser_chunk_s;
    logic                    ser_last_s;

    io_payload_serializer #(
        .INPUT_DATA_L (INPUT_DATA_L),
        .INPUT_REG_L  (INPUT_REG_L)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ser_load_s),
        .payload_i   (cmd_bus.cmd_payload),
        .beat_i      (ser_beat_s),
        .chunk_o     (ser_chunk_s),
        .last_beat_o (ser_last_s)
    );

    // Handshake flags and busy are decoded from the state register.
    assign cmd_bus.cmd_rdy  = (state_q == ST_IDLE);
    assign cmd_bus.rsp_vld  = (state_q == ST_RESP);
    assign cmd_bus.rsp_data = rsp_data_q;
    assign busy             = (state_q != ST_IDLE);
    assign io_in            = io_in_q;
    assign io_opcode        = io_opcode_q;

    // FSM next state. The io_* pins are computed one cycle ahead, so their
    // flops drive the value that belongs to the state being entered.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = wait_q;
        rsp_data_d  = rsp_data_q;
        io_in_d     = {INPUT_DATA_L{1'b0}};
        io_opcode_d = IO_OPCODE_L'(IO_NOP);
        ser_load_s  = 1'b0;
        ser_beat_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_bus.cmd_vld) begin
                    op_d        = cmd_bus.cmd_op;
                    ser_load_s  = 1'b1;
                    state_d     = ST_SHIFT;
                    io_opcode_d = IO_OPCODE_L'(IO_REG_SHIFT);
                    io_in_d     = ser_chunk_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ser_last_s) begin
                    state_d = ST_ISSUE;
                    // CONFIG leaves io_in at 0 while its opcode is issued.
                    case (op_q)
                        CMD_WRITE:   io_opcode_d = IO_OPCODE_L'(IO_WR);
                        CMD_READ:    io_opcode_d = IO_OPCODE_L'(IO_RD);
                        CMD_CONFIG:  io_opcode_d = IO_OPCODE_L'(IO_CONFIG_SHIFT);
                        CMD_MONITOR: io_opcode_d = IO_OPCODE_L'(IO_MONITOR);
                        default:     io_opcode_d = IO_OPCODE_L'(IO_NOP);
                    endcase
                end else begin
                    ser_beat_s  = 1'b1;
                    io_opcode_d = IO_OPCODE_L'(IO_REG_SHIFT);
                    io_in_d     = ser_chunk_s;
                end
            end
            ST_ISSUE: begin
                case (op_q)
                    CMD_WRITE: begin
                        state_d = ST_IDLE;
                    end
                    CMD_READ: begin
                        wait_d  = {WAIT_W{1'b0}};
                        state_d = ST_WAIT;
                    end
                    CMD_CONFIG, CMD_MONITOR: begin
                        rsp_data_d = io_out;
                        state_d    = ST_RESP;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_WAIT: begin
                // The read data appears RD_LAT cycles after the IO_RD cycle.
                // That is the last of RD_LAT WAIT cycles.
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    rsp_data_d = io_out;
                    state_d    = ST_RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RESP: begin
                if (cmd_bus.rsp_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs. A synchronous reset aborts any
    // command in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= CMD_WRITE;
            wait_q      <= {WAIT_W{1'b0}};
            rsp_data_q  <= {OUT_L{1'b0}};
            io_in_q     <= {INPUT_DATA_L{1'b0}};
            io_opcode_q <= IO_OPCODE_L'(IO_NOP);
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wait_q      <= wait_d;
            rsp_data_q  <= rsp_data_d;
            io_in_q     <= io_in_d;
            io_opcode_q <= io_opcode_d;
        end
    end

endmodule
